// File: rtl/aer_rate_encoder.sv
// aer_rate_encoder: buffers one sample of pixels and replays it as TIME_STEP
// rounds of rate-coded AER spike events, each round closed by a tick event,
// over a 4-phase REQ/ACK link.
module aer_rate_encoder #(
  parameter int                   TIME_STEP    = 8,
  parameter int                   INPUT_NEURON = 784,
  parameter int                   AER_WIDTH    = 12,
  parameter int                   PIX_WIDTH    = 8,
  parameter int                   ADDR_WIDTH   = 10,
  parameter logic [PIX_WIDTH-1:0] ACC_INIT     = 8'h80,
  parameter logic [AER_WIDTH-1:0] TICK_ADDR    = 12'hC00,
  localparam int                  STEP_W       = $clog2(TIME_STEP) + 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  PIX_WE,
  input  logic [ADDR_WIDTH-1:0] PIX_ADDR,
  input  logic [PIX_WIDTH-1:0]  PIX_DATA,
  input  logic                  START,
  output logic [AER_WIDTH-1:0]  AER_ADDR,
  output logic                  AER_REQ,
  input  logic                  AER_ACK,
  input  logic                  CORE_DONE,
  output logic                  BUSY,
  output logic [STEP_W-1:0]     STEP,
  output logic                  SAMPLE_DONE
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(INPUT_NEURON - 1);
  localparam logic [STEP_W-1:0]     LAST_STEP = STEP_W'(TIME_STEP - 1);

  typedef enum logic [3:0] {
    IDLE, RD, EV, REQ, ACKLO, ADV, TREQ, TACKLO, WAITC
  } state_t;

  state_t state, state_d;

  logic [ADDR_WIDTH-1:0] idx;
  logic [PIX_WIDTH-1:0]  pix_ram [INPUT_NEURON];
  logic [PIX_WIDTH-1:0]  acc_ram [INPUT_NEURON];
  logic [PIX_WIDTH-1:0]  pix_q, acc_q, acc_old;
  logic [PIX_WIDTH:0]    sum;
  logic                  spike, last_idx, last_step;

  // Round 0 ignores whatever the accumulator RAM holds, so it never needs clearing.
  assign acc_old   = (STEP == '0) ? ACC_INIT : acc_q;
  assign sum       = {1'b0, acc_old} + {1'b0, pix_q};
  assign spike     = sum[PIX_WIDTH];
  assign last_idx  = (idx == LAST_IDX);
  assign last_step = (STEP == LAST_STEP);
  assign BUSY      = (state != IDLE);

  // Pixel / accumulator RAMs: synchronous read of idx, no reset on contents.
  always_ff @(posedge CLK) begin
    if (PIX_WE && state == IDLE && PIX_ADDR <= LAST_IDX) pix_ram[PIX_ADDR] <= PIX_DATA;
    if (state == EV) acc_ram[idx] <= sum[PIX_WIDTH-1:0];
    pix_q <= pix_ram[idx];
    acc_q <= acc_ram[idx];
  end

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (START) state_d = RD;
      RD:      state_d = EV;
      EV:      state_d = spike ? REQ : ADV;
      REQ:     if (AER_REQ && AER_ACK) state_d = ACKLO;
      ACKLO:   if (!AER_ACK) state_d = ADV;
      ADV:     state_d = last_idx ? TREQ : RD;
      TREQ:    if (AER_REQ && AER_ACK) state_d = TACKLO;
      TACKLO:  if (!AER_ACK) state_d = last_step ? WAITC : RD;
      WAITC:   if (CORE_DONE) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Counters and link outputs; REQ is raised on entry when ACK is already low,
  // otherwise from within the request state once ACK falls.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      idx         <= '0;
      STEP        <= '0;
      AER_REQ     <= 1'b0;
      AER_ADDR    <= '0;
      SAMPLE_DONE <= 1'b0;
    end else begin
      SAMPLE_DONE <= 1'b0;
      case (state)
        IDLE: if (START) begin
          idx  <= '0;
          STEP <= '0;
        end
        EV: if (spike) begin
          AER_ADDR <= AER_WIDTH'(idx);
          if (!AER_ACK) AER_REQ <= 1'b1;
        end
        REQ, TREQ: begin
          if (!AER_REQ && !AER_ACK)    AER_REQ <= 1'b1;
          else if (AER_REQ && AER_ACK) AER_REQ <= 1'b0;
        end
        ADV: begin
          if (last_idx) begin
            AER_ADDR <= TICK_ADDR;
            if (!AER_ACK) AER_REQ <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        TACKLO: if (!AER_ACK && !last_step) begin
          STEP <= STEP + 1'b1;
          idx  <= '0;
        end
        WAITC: if (CORE_DONE) begin
          SAMPLE_DONE <= 1'b1;
          STEP        <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
